esfa_arbiter: RTL and testbench

ESFA_ARBITER -- requirements
Module: esfa_arbiter

---
 rtl/esfa_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_esfa_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/esfa_arbiter.sv
// rtl/esfa_arbiter.sv - two-requester command arbiter in front of the ESFA cell array
//
// Purpose: waits for the cell array to report an all-zero tree result
// (initialisation finished), then serves WRITE / META / QUERY commands from
// two requesters one at a time and returns a one-cycle response strobe to the
// requester that issued each command.
//
// Parameter:
//   QUERY_WAIT       cycles (1..15) the query selector is held before the tree
//                    result is sampled
// Optional build macro:
//   ESFA_ARB_RR_EN   defined: round-robin arbitration (A first after reset)
//                    undefined: fixed priority, A always wins over B
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   a_req_* / b_req_*            command inputs (valid, op, index, value, sel)
//                                and combinational ready (IDLE grant only)
//   a_rsp_* / b_rsp_*            registered response strobe, flag and data
//   arr_willWrite, arr_isMetadata,
//   arr_new_index, arr_new_value,
//   arr_metadata, arr_selector   registered cell array / combinator tree drive
//   arr_resultBool, arr_resultValue  tree result inputs
//   init_done                    array initialised, arbitration enabled
module esfa_arbiter #(
  parameter int unsigned QUERY_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset_n,

  input  logic       a_req_valid,
  output logic       a_req_ready,
  input  logic [1:0] a_req_op,
  input  logic [7:0] a_req_index,
  input  logic [7:0] a_req_value,
  input  logic [7:0] a_req_sel,
  output logic       a_rsp_valid,
  output logic       a_rsp_bool,
  output logic [7:0] a_rsp_value,

  input  logic       b_req_valid,
  output logic       b_req_ready,
  input  logic [1:0] b_req_op,
  input  logic [7:0] b_req_index,
  input  logic [7:0] b_req_value,
  input  logic [7:0] b_req_sel,
  output logic       b_rsp_valid,
  output logic       b_rsp_bool,
  output logic [7:0] b_rsp_value,

  output logic       arr_willWrite,
  output logic [7:0] arr_new_index,
  output logic [7:0] arr_new_value,
  output logic [7:0] arr_metadata,
  output logic       arr_isMetadata,
  output logic [7:0] arr_selector,
  input  logic       arr_resultBool,
  input  logic [7:0] arr_resultValue,

  output logic       init_done
);

  typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_META  = 2'b01;
  localparam logic [1:0] OP_QUERY = 2'b10;
  localparam logic [3:0] WAIT_LAST = 4'(QUERY_WAIT - 1);

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic       owner_b_q, owner_b_d;   // 1: command in flight belongs to B
  logic [3:0] cnt_q, cnt_d;
  logic       init_done_d;

  logic       will_write_d, is_meta_d;
  logic [7:0] new_index_d, new_value_d, metadata_d, selector_d;
  logic       a_rsp_valid_d, a_rsp_bool_d, b_rsp_valid_d, b_rsp_bool_d;
  logic [7:0] a_rsp_value_d, b_rsp_value_d;

  logic       grant_a, grant_b;
  logic [1:0] req_op;
  logic [7:0] req_index, req_value, req_sel;
  logic       load_rsp, rsp_bool_n;
  logic [7:0] rsp_value_n;

`ifdef ESFA_ARB_RR_EN
  logic prefer_b_q, prefer_b_d;       // 1: B wins the next tie

  assign grant_a = a_req_valid && (!b_req_valid || !prefer_b_q);
  assign grant_b = b_req_valid && (!a_req_valid || prefer_b_q);
`else
  assign grant_a = a_req_valid;
  assign grant_b = b_req_valid && !a_req_valid;
`endif

  // Command fields of whichever requester is being granted this cycle.
  assign req_op    = grant_b ? b_req_op    : a_req_op;
  assign req_index = grant_b ? b_req_index : a_req_index;
  assign req_value = grant_b ? b_req_value : a_req_value;
  assign req_sel   = grant_b ? b_req_sel   : a_req_sel;

  // Array-side registers are loaded at grant time so they are already valid
  // during ISSUE; they double as the latched copy of index/value/sel.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    owner_b_d     = owner_b_q;
    cnt_d         = cnt_q;
    init_done_d   = init_done;
    will_write_d  = 1'b0;
    is_meta_d     = 1'b0;
    new_index_d   = arr_new_index;
    new_value_d   = arr_new_value;
    metadata_d    = arr_metadata;
    selector_d    = arr_selector;
    a_rsp_valid_d = 1'b0;
    a_rsp_bool_d  = a_rsp_bool;
    a_rsp_value_d = a_rsp_value;
    b_rsp_valid_d = 1'b0;
    b_rsp_bool_d  = b_rsp_bool;
    b_rsp_value_d = b_rsp_value;
    a_req_ready   = 1'b0;
    b_req_ready   = 1'b0;
    load_rsp      = 1'b0;
    rsp_bool_n    = 1'b0;
    rsp_value_n   = 8'h00;
`ifdef ESFA_ARB_RR_EN
    prefer_b_d    = prefer_b_q;
`endif

    case (state_q)
      INIT: begin
        if (!arr_resultBool && (arr_resultValue == 8'h00)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end

      IDLE: begin
        if (grant_a || grant_b) begin
          a_req_ready = grant_a;
          b_req_ready = grant_b;
          op_d        = req_op;
          owner_b_d   = grant_b;
          state_d     = ISSUE;
`ifdef ESFA_ARB_RR_EN
          prefer_b_d  = grant_a;
`endif
          case (req_op)
            OP_WRITE: begin
              will_write_d = 1'b1;
              new_index_d  = req_index;
              new_value_d  = req_value;
            end
            OP_META: begin
              will_write_d = 1'b1;
              is_meta_d    = 1'b1;
              metadata_d   = req_value;
            end
            OP_QUERY: selector_d = req_sel;
            default: ;  // reserved op: no array access
          endcase
        end
      end

      ISSUE: begin
        if (op_q == OP_QUERY) begin
          cnt_d   = WAIT_LAST;
          state_d = WAIT;
        end else begin
          state_d     = RESP;
          load_rsp    = 1'b1;
          rsp_bool_n  = (op_q == OP_WRITE) || (op_q == OP_META);
          rsp_value_n = 8'h00;
        end
      end

      WAIT: begin
        if (cnt_q == 4'd0) begin
          // Last WAIT cycle: the tree result is captured here.
          state_d     = RESP;
          load_rsp    = 1'b1;
          rsp_bool_n  = arr_resultBool;
          rsp_value_n = arr_resultValue;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: state_d = IDLE;

      default: state_d = INIT;
    endcase

    if (load_rsp) begin
      if (owner_b_q) begin
        b_rsp_valid_d = 1'b1;
        b_rsp_bool_d  = rsp_bool_n;
        b_rsp_value_d = rsp_value_n;
      end else begin
        a_rsp_valid_d = 1'b1;
        a_rsp_bool_d  = rsp_bool_n;
        a_rsp_value_d = rsp_value_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= INIT;
      op_q           <= 2'b00;
      owner_b_q      <= 1'b0;
      cnt_q          <= 4'd0;
      init_done      <= 1'b0;
      arr_willWrite  <= 1'b0;
      arr_isMetadata <= 1'b0;
      arr_new_index  <= 8'h00;
      arr_new_value  <= 8'h00;
      arr_metadata   <= 8'h00;
      arr_selector   <= 8'h00;
      a_rsp_valid    <= 1'b0;
      a_rsp_bool     <= 1'b0;
      a_rsp_value    <= 8'h00;
      b_rsp_valid    <= 1'b0;
      b_rsp_bool     <= 1'b0;
      b_rsp_value    <= 8'h00;
`ifdef ESFA_ARB_RR_EN
      prefer_b_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      owner_b_q      <= owner_b_d;
      cnt_q          <= cnt_d;
      init_done      <= init_done_d;
      arr_willWrite  <= will_write_d;
      arr_isMetadata <= is_meta_d;
      arr_new_index  <= new_index_d;
      arr_new_value  <= new_value_d;
      arr_metadata   <= metadata_d;
      arr_selector   <= selector_d;
      a_rsp_valid    <= a_rsp_valid_d;
      a_rsp_bool     <= a_rsp_bool_d;
      a_rsp_value    <= a_rsp_value_d;
      b_rsp_valid    <= b_rsp_valid_d;
      b_rsp_bool     <= b_rsp_bool_d;
      b_rsp_value    <= b_rsp_value_d;
`ifdef ESFA_ARB_RR_EN
      prefer_b_q     <= prefer_b_d;
`endif
    end
  end

endmodule

// File: tb/tb_esfa_arbiter.sv
// tb/tb_esfa_arbiter.sv - randomized self-checking bench for esfa_arbiter
module tb_esfa_arbiter;

  localparam int QW = 2;
  localparam logic [1:0] OP_W = 2'b00;
  localparam logic [1:0] OP_M = 2'b01;
  localparam logic [1:0] OP_Q = 2'b10;
  localparam logic [1:0] OP_R = 2'b11;
`ifdef ESFA_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       a_req_valid = 1'b0, b_req_valid = 1'b0;
  logic [1:0] a_req_op = 2'b00, b_req_op = 2'b00;
  logic [7:0] a_req_index = 8'h00, a_req_value = 8'h00, a_req_sel = 8'h00;
  logic [7:0] b_req_index = 8'h00, b_req_value = 8'h00, b_req_sel = 8'h00;
  logic       a_req_ready, b_req_ready;
  logic       a_rsp_valid, a_rsp_bool, b_rsp_valid, b_rsp_bool;
  logic [7:0] a_rsp_value, b_rsp_value;
  logic       arr_willWrite, arr_isMetadata, init_done;
  logic [7:0] arr_new_index, arr_new_value, arr_metadata, arr_selector;
  logic       arr_resultBool;
  logic [7:0] arr_resultValue;

  // Combinator tree stand-in: a lookup table indexed by the selector, or a
  // forced value while the array is still initialising.
  logic [8:0] tbl [256];
  logic       init_ovr = 1'b1;
  logic [8:0] ovr_val = 9'h100;
  assign {arr_resultBool, arr_resultValue} = init_ovr ? ovr_val : tbl[arr_selector];

  int n_tests = 0;
  int n_fail = 0;
  logic       m_prefer_b = 1'b0;
  logic [7:0] m_sel = 8'h00;

  esfa_arbiter #(.QUERY_WAIT(QW)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_op(a_req_op),
    .a_req_index(a_req_index), .a_req_value(a_req_value), .a_req_sel(a_req_sel),
    .a_rsp_valid(a_rsp_valid), .a_rsp_bool(a_rsp_bool), .a_rsp_value(a_rsp_value),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_op(b_req_op),
    .b_req_index(b_req_index), .b_req_value(b_req_value), .b_req_sel(b_req_sel),
    .b_rsp_valid(b_rsp_valid), .b_rsp_bool(b_rsp_bool), .b_rsp_value(b_rsp_value),
    .arr_willWrite(arr_willWrite), .arr_new_index(arr_new_index),
    .arr_new_value(arr_new_value), .arr_metadata(arr_metadata),
    .arr_isMetadata(arr_isMetadata), .arr_selector(arr_selector),
    .arr_resultBool(arr_resultBool), .arr_resultValue(arr_resultValue),
    .init_done(init_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT in INIT and reset_n already high.
  task automatic do_init(input int busy);
    init_ovr = 1'b1;
    ovr_val = 9'h100;
    a_req_valid = 1'b1;
    b_req_valid = 1'b1;
    repeat (busy) begin
      @(negedge clk);
      check("init_done_low", init_done, 0);
      check("init_ready", a_req_ready | b_req_ready, 0);
    end
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    ovr_val = 9'h000;
    @(negedge clk);
    check("init_done_high", init_done, 1);
    init_ovr = 1'b0;
  endtask

  // Called at a negedge with the DUT idle and the request inputs just driven.
  // Predicts the winner, then walks every cycle up to the response.
  task automatic run_cmd();
    logic       any, win_b;
    logic [1:0] op;
    logic [7:0] idx, val, sel;
    logic [8:0] exp_rsp;
    int         lat;
    #1;
    any = a_req_valid || b_req_valid;
    if (a_req_valid && b_req_valid) win_b = RR ? m_prefer_b : 1'b0;
    else win_b = b_req_valid;
    check("a_ready", a_req_ready, any && !win_b);
    check("b_ready", b_req_ready, any && win_b);
    if (!any) return;
    op  = win_b ? b_req_op    : a_req_op;
    idx = win_b ? b_req_index : a_req_index;
    val = win_b ? b_req_value : a_req_value;
    sel = win_b ? b_req_sel   : a_req_sel;
    m_prefer_b = !win_b;
    lat = (op == OP_Q) ? 2 + QW : 2;
    if (op == OP_Q) begin
      m_sel = sel;
      exp_rsp = tbl[sel];
    end else if (op == OP_R) begin
      exp_rsp = 9'h000;
    end else begin
      exp_rsp = 9'h100;
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check("busy_ready", a_req_ready | b_req_ready, 0);
      check("wr_strobe", arr_willWrite, (k == 1) && (op == OP_W || op == OP_M));
      check("is_meta", arr_isMetadata, (k == 1) && (op == OP_M));
      check("selector", arr_selector, m_sel);
      if (k == 1 && op == OP_W) check("wr_data", {arr_new_index, arr_new_value}, {idx, val});
      if (k == 1 && op == OP_M) check("meta_data", arr_metadata, val);
      check("a_rsp_valid", a_rsp_valid, (k == lat) && !win_b);
      check("b_rsp_valid", b_rsp_valid, (k == lat) && win_b);
      if (k == lat) begin
        if (win_b) check("b_rsp", {b_rsp_bool, b_rsp_value}, exp_rsp);
        else check("a_rsp", {a_rsp_bool, a_rsp_value}, exp_rsp);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) tbl[i] = 9'($urandom);
    tbl[3] = 9'h15A;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_arr_data", {arr_new_index, arr_new_value, arr_metadata, arr_selector}, 0);
    check("rst_ctl", {arr_willWrite, arr_isMetadata, init_done, a_rsp_valid, b_rsp_valid}, 0);
    check("rst_rsp", {a_rsp_bool, a_rsp_value, b_rsp_bool, b_rsp_value}, 0);
    reset_n = 1'b1;
    do_init(3);

    // Directed: WRITE from A
    @(negedge clk);
    a_req_valid = 1'b1; a_req_op = OP_W; a_req_index = 8'd3; a_req_value = 8'h5A;
    b_req_valid = 1'b0;
    run_cmd();
    // Directed: QUERY from B
    @(negedge clk);
    a_req_valid = 1'b0;
    b_req_valid = 1'b1; b_req_op = OP_Q; b_req_sel = 8'd3;
    run_cmd();
    // Directed: reserved op from A
    @(negedge clk);
    a_req_valid = 1'b1; a_req_op = OP_R;
    b_req_valid = 1'b0;
    run_cmd();
    // Directed: META from B
    @(negedge clk);
    a_req_valid = 1'b0;
    b_req_valid = 1'b1; b_req_op = OP_M; b_req_value = 8'hC3;
    run_cmd();

    // Contention: both requesters valid the whole time
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      a_req_valid = 1'b1; a_req_op = OP_W; a_req_index = 8'(r); a_req_value = 8'(8'h10 + r);
      b_req_valid = 1'b1; b_req_op = OP_M; b_req_value = 8'(8'h80 + r);
      run_cmd();
    end

    // Random traffic, including idle cycles and dropped requests
    for (int r = 0; r < 40; r++) begin
      @(negedge clk);
      a_req_valid = 1'($urandom_range(0, 1));
      a_req_op    = 2'($urandom_range(0, 3));
      a_req_index = 8'($urandom);
      a_req_value = 8'($urandom);
      a_req_sel   = 8'($urandom);
      b_req_valid = 1'($urandom_range(0, 1));
      b_req_op    = 2'($urandom_range(0, 3));
      b_req_index = 8'($urandom);
      b_req_value = 8'($urandom);
      b_req_sel   = 8'($urandom);
      run_cmd();
    end

    // Reset during WAIT of a QUERY from A
    @(negedge clk);
    a_req_valid = 1'b1; a_req_op = OP_Q; a_req_sel = 8'h77;
    b_req_valid = 1'b0;
    #1;
    check("abort_grant", a_req_ready, 1);
    @(negedge clk);  // ISSUE
    a_req_valid = 1'b0;
    @(negedge clk);  // first WAIT cycle
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_ctl", {arr_willWrite, arr_isMetadata, init_done, a_rsp_valid, b_rsp_valid}, 0);
    check("abort_arr_data", {arr_new_index, arr_new_value, arr_metadata, arr_selector}, 0);
    check("abort_rsp", {a_rsp_bool, a_rsp_value, b_rsp_bool, b_rsp_value}, 0);
    @(negedge clk);
    check("abort_no_rsp", {a_rsp_valid, b_rsp_valid}, 0);
    m_prefer_b = 1'b0;
    m_sel = 8'h00;
    reset_n = 1'b1;
    do_init(1);

    // Priority after reset: A must win a tie
    @(negedge clk);
    a_req_valid = 1'b1; a_req_op = OP_W; a_req_index = 8'h21; a_req_value = 8'h42;
    b_req_valid = 1'b1; b_req_op = OP_W; b_req_index = 8'h31; b_req_value = 8'h52;
    run_cmd();
    @(negedge clk);
    run_cmd();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
